axi_ram_slave: RTL and testbench

Single-beat AXI3 slave memory model sitting directly downstream of the CPU's AXI bridge: it consumes the bridge's AR/AW/W requests and produces R/B responses from an internal word-addressed RAM. It stands in for the SoC memory in simulation and FPGA bring-up. It supports one outstanding read and one outstanding write at a time, with a fixed, programmable read latency. Ignored bridge outputs (arlen/awlen, arsize/awsize, arburst/awburst, lock/cache/prot, wid, wlast) are not ported.

---
 rtl/axi_ram_pkg.sv | 22 ++
 rtl/axi_ram_lfsr16.sv | 23 ++
 rtl/axi_ram_slave.sv | 203 ++++++++++++++++++++
 tb/tb_axi_ram_slave.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ram_pkg.sv
// Shared types and constants for the single-beat AXI3 RAM slave.
package axi_ram_pkg;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_COLLECT,
        W_RESP
    } wr_state_t;

    localparam logic [1:0]  RESP_OKAY = 2'b00;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/axi_ram_lfsr16.sv
// 16-bit Galois LFSR with synchronous reset to a seed; drives the optional
// ready-stall pattern of axi_ram_slave.
module lfsr16
    import axi_ram_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED,
    parameter logic [15:0] TAPS = LFSR_TAPS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEED;
        end else if (en) begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/axi_ram_slave.sv
// Single-beat AXI3 slave RAM: one outstanding read (fixed READ_LAT) and one
// outstanding write. Define AXI_RAM_RAND_DELAY_EN to add LFSR-driven ready stalls.
module axi_ram_slave
    import axi_ram_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned READ_LAT  = 2
) (
    input  logic        aclk,
    input  logic        reset,

    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,

    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,

    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,

    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,

    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;
    localparam int unsigned CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LAT - 1);

    logic [31:0] mem [DEPTH];

    logic ar_stall, aw_stall, w_stall;

`ifdef AXI_RAM_RAND_DELAY_EN
    localparam int unsigned AR_STALL_BIT = 0;
    localparam int unsigned AW_STALL_BIT = 5;
    localparam int unsigned W_STALL_BIT  = 10;

    logic [15:0] lfsr_state;
    logic        unused_lfsr_bits;

    lfsr16 #(
        .SEED (LFSR_SEED),
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk   (aclk),
        .reset (reset),
        .en    (1'b1),
        .state (lfsr_state)
    );

    assign ar_stall = lfsr_state[AR_STALL_BIT];
    assign aw_stall = lfsr_state[AW_STALL_BIT];
    assign w_stall  = lfsr_state[W_STALL_BIT];
    assign unused_lfsr_bits = ^{lfsr_state[15:11], lfsr_state[9:6], lfsr_state[4:1]};
`else
    assign ar_stall = 1'b0;
    assign aw_stall = 1'b0;
    assign w_stall  = 1'b0;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^{araddr[31:ADDR_BITS+2], araddr[1:0],
                                awaddr[31:ADDR_BITS+2], awaddr[1:0]};

    assign rresp = RESP_OKAY;
    assign rlast = 1'b1;
    assign bresp = RESP_OKAY;

    // ---------------- read path ----------------
    rd_state_t            rd_state, rd_next;
    logic [CNT_W-1:0]     rd_cnt;
    logic [ADDR_BITS-1:0] rd_idx;
    logic                 ar_hs, r_hs, rd_sample;

    always_comb begin
        ar_hs     = arvalid && arready;
        r_hs      = rvalid && rready;
        rd_sample = (rd_state == R_WAIT) && (rd_cnt == '0);
        rd_next   = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs)     rd_next = R_WAIT;
            R_WAIT:  if (rd_sample) rd_next = R_RESP;
            R_RESP:  if (r_hs)      rd_next = R_IDLE;
            default:                rd_next = R_IDLE;
        endcase
    end

    // Readies and valids are registered from the next state so that no
    // input reaches an output combinationally.
    always_ff @(posedge aclk) begin
        if (reset) begin
            rd_state <= R_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rid      <= '0;
            rd_cnt   <= '0;
            rd_idx   <= '0;
        end else begin
            rd_state <= rd_next;
            arready  <= (rd_next == R_IDLE) && !ar_stall;
            rvalid   <= (rd_next == R_RESP);
            if (ar_hs) begin
                rid    <= arid;
                rd_idx <= araddr[ADDR_BITS+1:2];
                rd_cnt <= LAT_LOAD;
            end else if ((rd_state == R_WAIT) && (rd_cnt != '0)) begin
                rd_cnt <= rd_cnt - CNT_W'(1);
            end
            if (rd_sample) begin
                rdata <= mem[rd_idx];
            end
        end
    end

    // ---------------- write path ----------------
    wr_state_t            wr_state, wr_next;
    logic                 aw_held, w_held, aw_held_nx, w_held_nx;
    logic [ADDR_BITS-1:0] wr_idx;
    logic [31:0]          wr_data;
    logic [3:0]           wr_strb;
    logic                 aw_hs, w_hs, b_hs, commit;

    always_comb begin
        aw_hs      = awvalid && awready;
        w_hs       = wvalid && wready;
        b_hs       = bvalid && bready;
        commit     = (wr_state == W_COLLECT) && aw_held && w_held;
        aw_held_nx = aw_held;
        w_held_nx  = w_held;
        if (commit) begin
            aw_held_nx = 1'b0;
            w_held_nx  = 1'b0;
        end else begin
            if (aw_hs) aw_held_nx = 1'b1;
            if (w_hs)  w_held_nx  = 1'b1;
        end
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:    if (aw_hs || w_hs) wr_next = W_COLLECT;
            W_COLLECT: if (commit)        wr_next = W_RESP;
            W_RESP:    if (b_hs)          wr_next = W_IDLE;
            default:                      wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            wr_state <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bid      <= '0;
            wr_idx   <= '0;
            wr_data  <= '0;
            wr_strb  <= '0;
        end else begin
            wr_state <= wr_next;
            aw_held  <= aw_held_nx;
            w_held   <= w_held_nx;
            awready  <= (wr_next != W_RESP) && !aw_held_nx && !aw_stall;
            wready   <= (wr_next != W_RESP) && !w_held_nx && !w_stall;
            bvalid   <= (wr_next == W_RESP);
            if (aw_hs) begin
                bid    <= awid;
                wr_idx <= awaddr[ADDR_BITS+1:2];
            end
            if (w_hs) begin
                wr_data <= wdata;
                wr_strb <= wstrb;
            end
        end
    end

    // RAM is never cleared; a same-edge read sample sees the pre-commit word.
    always_ff @(posedge aclk) begin
        if (commit && !reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Self-checking bench for axi_ram_slave: directed scenarios plus a randomized
// run against a word/byte-mask reference memory.
module tb_axi_ram_slave;

    localparam int unsigned ADDR_BITS = 16;
    localparam int unsigned READ_LAT  = 2;
    localparam logic [31:0] TOP_WORD  = ((32'd1 << ADDR_BITS) - 1) << 2;
    localparam logic [31:0] ALIAS_BIT = 32'd1 << (ADDR_BITS + 2);

    logic        aclk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    axi_ram_slave #(
        .ADDR_BITS (ADDR_BITS),
        .READ_LAT  (READ_LAT)
    ) dut (
        .aclk    (aclk),
        .reset   (reset),
        .arid    (arid),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready),
        .awid    (awid),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bid     (bid),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    always #5 aclk = ~aclk;

    int          n_checks = 0;
    int          n_fails  = 0;
    int unsigned cyc = 0;
    int unsigned cnt_ar = 0, cnt_r = 0, cnt_aw = 0, cnt_w = 0, cnt_b = 0;

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (arvalid && arready) cnt_ar <= cnt_ar + 1;
        if (rvalid && rready)   cnt_r  <= cnt_r + 1;
        if (awvalid && awready) cnt_aw <= cnt_aw + 1;
        if (wvalid && wready)   cnt_w  <= cnt_w + 1;
        if (bvalid && bready)   cnt_b  <= cnt_b + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference memory: word index -> contents, only for words written by the random run.
    logic [31:0]  model [int unsigned];
    int unsigned  written_q[$];

    function automatic logic [31:0] apply_strb(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // ---------------- channel drivers (phase: called and return at posedge+1) ----------------
    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
                           output int unsigned hs_cyc, output bit ok);
        arid = id; araddr = addr; arvalid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge aclk);
            if (arready) begin ok = 1'b1; break; end
        end
        @(posedge aclk); #1;
        hs_cyc = cyc; arvalid = 1'b0;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                           output int unsigned hs_cyc, output bit ok);
        awid = id; awaddr = addr; awvalid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge aclk);
            if (awready) begin ok = 1'b1; break; end
        end
        @(posedge aclk); #1;
        hs_cyc = cyc; awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb,
                          output int unsigned hs_cyc, output bit ok);
        wdata = data; wstrb = strb; wvalid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge aclk);
            if (wready) begin ok = 1'b1; break; end
        end
        @(posedge aclk); #1;
        hs_cyc = cyc; wvalid = 1'b0;
    endtask

    task automatic wait_r(input int hold, output logic [31:0] data, output logic [3:0] id_o,
                          output logic [2:0] last_resp, output int unsigned seen_cyc,
                          output bit ok, output bit stable);
        ok = 1'b0; stable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge aclk);
            if (rvalid) begin ok = 1'b1; break; end
        end
        seen_cyc = cyc; data = rdata; id_o = rid; last_resp = {rlast, rresp};
        if (ok) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge aclk);
                if (!(rvalid === 1'b1 && rdata === data && rid === id_o && arready === 1'b0))
                    stable = 1'b0;
            end
            rready = 1'b1;
        end
        @(posedge aclk); #1;
        rready = 1'b0;
    endtask

    task automatic wait_b(input int hold, output logic [3:0] bid_o, output logic [1:0] bresp_o,
                          output int unsigned seen_cyc, output bit ok, output bit stable);
        ok = 1'b0; stable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge aclk);
            if (bvalid) begin ok = 1'b1; break; end
        end
        seen_cyc = cyc; bid_o = bid; bresp_o = bresp;
        if (ok) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge aclk);
                if (!(bvalid === 1'b1 && bid === bid_o && awready === 1'b0 && wready === 1'b0))
                    stable = 1'b0;
            end
            bready = 1'b1;
        end
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    task automatic read_word(input logic [3:0] id, input logic [31:0] addr, input int hold,
                             output logic [31:0] data, output logic [3:0] id_o,
                             output logic [2:0] last_resp, output int lat,
                             output bit ok, output bit stable);
        int unsigned t0, t1;
        bit          ok_ar, ok_r;
        send_ar(id, addr, t0, ok_ar);
        wait_r(hold, data, id_o, last_resp, t1, ok_r, stable);
        ok  = ok_ar && ok_r;
        lat = int'(t1) - int'(t0);
    endtask

    // gap > 0: W leads AW by gap cycles; gap < 0: AW leads W.
    task automatic write_word(input logic [3:0] id, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] strb,
                              input int gap, input int hold,
                              output logic [3:0] bid_o, output logic [1:0] bresp_o,
                              output int lat, output bit ok, output bit stable);
        int unsigned t_aw, t_w, t_b;
        bit          ok_aw, ok_w, ok_b;
        fork
            begin
                if (gap > 0) repeat (gap) begin @(posedge aclk); #1; end
                send_aw(id, addr, t_aw, ok_aw);
            end
            begin
                if (gap < 0) repeat (-gap) begin @(posedge aclk); #1; end
                send_w(data, strb, t_w, ok_w);
            end
        join
        wait_b(hold, bid_o, bresp_o, t_b, ok_b, stable);
        ok  = ok_aw && ok_w && ok_b;
        lat = int'(t_b) - int'((t_aw > t_w) ? t_aw : t_w);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        n_checks++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b0) begin
            n_fails++;
            $display("FAIL reset_ctrl: got %b expected 00000", {arready, awready, wready, rvalid, bvalid});
        end
        n_checks++;
        if ({rdata, rid, bid} !== 40'h0) begin
            n_fails++;
            $display("FAIL reset_data: got rdata=%h rid=%h bid=%h expected zeros", rdata, rid, bid);
        end
        reset = 1'b0;
        @(negedge aclk);
`ifndef AXI_RAM_RAND_DELAY_EN
        n_checks++;
        if ({arready, awready, wready} !== 3'b111) begin
            n_fails++;
            $display("FAIL ready_rise: got %b expected 111", {arready, awready, wready});
        end
`endif
        @(posedge aclk); #1;
    endtask

    task automatic test_basic();
        logic [3:0] b, r_id; logic [1:0] br; logic [31:0] d; logic [2:0] lr;
        int lat; bit ok, st;
        write_word(4'h1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, b, br, lat, ok, st);
        n_checks++;
        if ({ok, b, br} !== {1'b1, 4'h1, 2'b00}) begin
            n_fails++;
            $display("FAIL basic_b: got ok=%b bid=%h bresp=%b expected 1/1/00", ok, b, br);
        end
        n_checks++;
        if (lat !== 1) begin
            n_fails++;
            $display("FAIL basic_b_lat: got %0d expected 1", lat);
        end
        read_word(4'h0, 32'h100, 0, d, r_id, lr, lat, ok, st);
        n_checks++;
        if ({ok, d, r_id} !== {1'b1, 32'hDEADBEEF, 4'h0}) begin
            n_fails++;
            $display("FAIL basic_r: got ok=%b rdata=%h rid=%h expected 1/deadbeef/0", ok, d, r_id);
        end
        n_checks++;
        if (lr !== 3'b100) begin
            n_fails++;
            $display("FAIL basic_rlast_rresp: got %b expected 100", lr);
        end
        n_checks++;
        if (lat !== READ_LAT) begin
            n_fails++;
            $display("FAIL basic_r_lat: got %0d expected %0d", lat, READ_LAT);
        end
    endtask

    task automatic test_order();
        logic [3:0] b, r_id; logic [1:0] br; logic [31:0] d; logic [2:0] lr;
        int lat, extra; bit ok, st;
        for (int k = 0; k < 2; k++) begin
            logic [31:0] a, v;
            a = (k == 0) ? 32'h200 : 32'h204;
            v = (k == 0) ? 32'h0A0B0C0D : 32'h55667788;
            write_word(4'(2 + k), a, v, 4'hF, (k == 0) ? 3 : -3, 0, b, br, lat, ok, st);
            n_checks++;
            if ({ok, b, lat} !== {1'b1, 4'(2 + k), 32'sd1}) begin
                n_fails++;
                $display("FAIL order_b[%0d]: got ok=%b bid=%h lat=%0d expected 1/%0d/1", k, ok, b, lat, 2 + k);
            end
            extra = 0;
            repeat (4) begin @(negedge aclk); if (bvalid) extra++; end
            @(posedge aclk); #1;
            n_checks++;
            if (extra !== 0) begin
                n_fails++;
                $display("FAIL order_extra_b[%0d]: got %0d extra bvalid cycles expected 0", k, extra);
            end
            read_word(4'h1, a, 0, d, r_id, lr, lat, ok, st);
            n_checks++;
            if ({ok, d} !== {1'b1, v}) begin
                n_fails++;
                $display("FAIL order_data[%0d]: got %h expected %h", k, d, v);
            end
        end
    endtask

    task automatic test_strobe();
        logic [3:0] b, r_id; logic [1:0] br; logic [31:0] d; logic [2:0] lr;
        int lat; bit ok, st;
        write_word(4'h4, 32'h300, 32'h11223344, 4'hF, 0, 0, b, br, lat, ok, st);
        write_word(4'h4, 32'h300, 32'hAABBCCDD, 4'b0101, 1, 0, b, br, lat, ok, st);
        read_word(4'h1, 32'h300, 0, d, r_id, lr, lat, ok, st);
        n_checks++;
        if (d !== 32'h11BB33DD) begin
            n_fails++;
            $display("FAIL strobe_merge: got %h expected 11bb33dd", d);
        end
        write_word(4'h9, 32'h300, 32'hFFFFFFFF, 4'h0, 0, 0, b, br, lat, ok, st);
        n_checks++;
        if ({ok, b, br} !== {1'b1, 4'h9, 2'b00}) begin
            n_fails++;
            $display("FAIL strobe_zero_b: got ok=%b bid=%h bresp=%b expected 1/9/00", ok, b, br);
        end
        read_word(4'h1, 32'h300, 0, d, r_id, lr, lat, ok, st);
        n_checks++;
        if (d !== 32'h11BB33DD) begin
            n_fails++;
            $display("FAIL strobe_zero_data: got %h expected 11bb33dd", d);
        end
    endtask

    task automatic test_alias();
        logic [3:0] b, r_id; logic [1:0] br; logic [31:0] d; logic [2:0] lr;
        int lat; bit ok, st;
        write_word(4'h2, ALIAS_BIT | 32'h403, 32'hCAFEF00D, 4'hF, 0, 0, b, br, lat, ok, st);
        read_word(4'h3, 32'h400, 0, d, r_id, lr, lat, ok, st);
        n_checks++;
        if (d !== 32'hCAFEF00D) begin
            n_fails++;
            $display("FAIL alias_low: got %h expected cafef00d", d);
        end
        write_word(4'h2, TOP_WORD, 32'h5A5AA5A5, 4'hF, 0, 0, b, br, lat, ok, st);
        read_word(4'h3, 32'hFFFC_0000 | TOP_WORD | 32'h1, 0, d, r_id, lr, lat, ok, st);
        n_checks++;
        if (d !== 32'h5A5AA5A5) begin
            n_fails++;
            $display("FAIL alias_top: got %h expected 5a5aa5a5", d);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] b, r_id; logic [1:0] br; logic [31:0] d; logic [2:0] lr;
        int lat; bit ok, st;
        write_word(4'h5, 32'h500, 32'h01020304, 4'hF, 0, 5, b, br, lat, ok, st);
        n_checks++;
        if ({ok, st, b} !== {2'b11, 4'h5}) begin
            n_fails++;
            $display("FAIL bp_b: got ok=%b stable=%b bid=%h expected 1/1/5", ok, st, b);
        end
        read_word(4'hE, 32'h500, 5, d, r_id, lr, lat, ok, st);
        n_checks++;
        if ({ok, st, d, r_id} !== {2'b11, 32'h01020304, 4'hE}) begin
            n_fails++;
            $display("FAIL bp_r: got ok=%b stable=%b rdata=%h rid=%h expected 1/1/01020304/e", ok, st, d, r_id);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] b, r_id; logic [1:0] br; logic [31:0] d; logic [2:0] lr;
        int lat; int unsigned t, tb_seen; bit ok, st, seen;
        send_ar(4'h7, 32'h100, t, ok);
        reset = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        n_checks++;
        if ({arready, awready, wready, rvalid, bvalid, rdata, rid, bid} !== 45'h0) begin
            n_fails++;
            $display("FAIL rst_rwait_vals: got ctl=%b rdata=%h rid=%h bid=%h expected zeros",
                     {arready, awready, wready, rvalid, bvalid}, rdata, rid, bid);
        end
        @(posedge aclk); #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (8) begin @(negedge aclk); if (rvalid || bvalid) seen = 1'b1; end
        @(posedge aclk); #1;
        n_checks++;
        if (seen !== 1'b0) begin
            n_fails++;
            $display("FAIL rst_rwait_resp: got response after reset, expected none");
        end
        read_word(4'h8, 32'h100, 0, d, r_id, lr, lat, ok, st);
        n_checks++;
        if ({ok, d, r_id} !== {1'b1, 32'hDEADBEEF, 4'h8}) begin
            n_fails++;
            $display("FAIL rst_reread: got ok=%b rdata=%h rid=%h expected 1/deadbeef/8", ok, d, r_id);
        end
        // Orphan W in W_COLLECT, then reset: the held W must be discarded.
        send_w(32'hBADC0FFE, 4'hF, t, ok);
        reset = 1'b1;
        repeat (2) @(posedge aclk);
        #1 reset = 1'b0;
        send_aw(4'h6, 32'h100, t, ok);
        seen = 1'b0;
        repeat (6) begin @(negedge aclk); if (bvalid) seen = 1'b1; end
        @(posedge aclk); #1;
        n_checks++;
        if (seen !== 1'b0) begin
            n_fails++;
            $display("FAIL rst_wcollect_resp: got bvalid with only AW held, expected none");
        end
        send_w(32'h12345678, 4'hF, t, ok);
        wait_b(0, b, br, tb_seen, ok, st);
        n_checks++;
        if ({ok, b, int'(tb_seen) - int'(t)} !== {1'b1, 4'h6, 32'sd1}) begin
            n_fails++;
            $display("FAIL rst_after_b: got ok=%b bid=%h lat=%0d expected 1/6/1", ok, b, int'(tb_seen) - int'(t));
        end
        read_word(4'h8, 32'h100, 0, d, r_id, lr, lat, ok, st);
        n_checks++;
        if (d !== 32'h12345678) begin
            n_fails++;
            $display("FAIL rst_after_data: got %h expected 12345678", d);
        end
    endtask

    task automatic test_random();
        int unsigned ar0, r0, aw0, w0, b0, exp_r, exp_w;
        logic [3:0] b, r_id, id; logic [1:0] br; logic [31:0] d, addr, v; logic [2:0] lr;
        logic [3:0] strb; int unsigned idx; int lat, gap, hold; bit ok, st;
        ar0 = cnt_ar; r0 = cnt_r; aw0 = cnt_aw; w0 = cnt_w; b0 = cnt_b;
        exp_r = 0; exp_w = 0;
        for (int t = 0; t < 200; t++) begin
            id   = 4'($urandom);
            hold = int'($urandom_range(0, 2));
            if (written_q.size() == 0 || $urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 3) == 0) idx = (32'd1 << ADDR_BITS) - 1 - $urandom_range(0, 3);
                else                           idx = $urandom_range(0, 31);
                strb = model.exists(idx) ? 4'($urandom) : 4'hF;
                v    = $urandom;
                addr = ($urandom << (ADDR_BITS + 2)) | (idx << 2) | $urandom_range(0, 3);
                gap  = int'($urandom_range(0, 6)) - 3;
                write_word(id, addr, v, strb, gap, hold, b, br, lat, ok, st);
                if (!model.exists(idx)) written_q.push_back(idx);
                model[idx] = apply_strb(model.exists(idx) ? model[idx] : 32'h0, v, strb);
                exp_w++;
                n_checks++;
                if ({ok, st, b, br, lat} !== {2'b11, id, 2'b00, 32'sd1}) begin
                    n_fails++;
                    $display("FAIL rnd_b[%0d]: got ok=%b stable=%b bid=%h bresp=%b lat=%0d expected 1/1/%h/00/1",
                             t, ok, st, b, br, lat, id);
                end
            end else begin
                idx  = written_q[$urandom_range(0, written_q.size() - 1)];
                addr = ($urandom << (ADDR_BITS + 2)) | (idx << 2) | $urandom_range(0, 3);
                read_word(id, addr, hold, d, r_id, lr, lat, ok, st);
                exp_r++;
                n_checks++;
                if (d !== model[idx]) begin
                    n_fails++;
                    $display("FAIL rnd_data[%0d]: idx=%0d got %h expected %h", t, idx, d, model[idx]);
                end
                n_checks++;
                if ({ok, st, r_id, lr, lat} !== {2'b11, id, 3'b100, READ_LAT}) begin
                    n_fails++;
                    $display("FAIL rnd_r[%0d]: got ok=%b stable=%b rid=%h last_resp=%b lat=%0d expected 1/1/%h/100/%0d",
                             t, ok, st, r_id, lr, lat, id, READ_LAT);
                end
            end
            repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
        end
        @(posedge aclk); #1;
        n_checks++;
        if ({cnt_ar - ar0, cnt_r - r0} !== {exp_r, exp_r}) begin
            n_fails++;
            $display("FAIL rnd_read_hs: got ar=%0d r=%0d expected %0d each", cnt_ar - ar0, cnt_r - r0, exp_r);
        end
        n_checks++;
        if ({cnt_aw - aw0, cnt_w - w0, cnt_b - b0} !== {exp_w, exp_w, exp_w}) begin
            n_fails++;
            $display("FAIL rnd_write_hs: got aw=%0d w=%0d b=%0d expected %0d each",
                     cnt_aw - aw0, cnt_w - w0, cnt_b - b0, exp_w);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_order();
        test_strobe();
        test_alias();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
